// File: rtl/gcd_host.sv
// Host sequencer for a 7-bit GCD engine: accepts one operand pair, starts the engine, returns the result.
// Optional GCD_TIMEOUT_EN macro aborts a run after TIMEOUT_CYCLES wait cycles with rsp_err=1.
module gcd_host #(
    parameter int TIMEOUT_CYCLES = 300
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [6:0] i_req_a,
    input  logic [6:0] i_req_b,
    output logic       o_eng_start,
    output logic [6:0] o_eng_a,
    output logic [6:0] o_eng_b,
    input  logic       i_eng_ready,
    input  logic [6:0] i_eng_r,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [6:0] o_rsp_gcd,
    output logic       o_rsp_coprime,
    output logic       o_rsp_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_eng_a;
    logic [6:0] r_eng_b;
    logic [6:0] r_rsp_gcd;
    logic       r_rsp_coprime;
    logic       w_accept;
    logic       w_done;
    logic       w_waiting;
    logic       w_timeout;

    assign w_accept  = (r_state == S_IDLE) && i_req_valid && i_eng_ready;
    assign w_done    = (r_state == S_WAIT_DONE) && i_eng_ready;
    assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);

`ifdef GCD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= '0;
        end else if (w_waiting) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A genuine result sampled in the same cycle as the limit wins over the abort.
    assign w_timeout = w_waiting && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !w_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (w_done) begin
            r_rsp_err <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_err <= 1'b1;
        end
    end
    assign o_rsp_err = r_rsp_err;
`else
    logic [31:0] w_unused_param;
    assign w_unused_param = 32'(TIMEOUT_CYCLES);
    assign w_timeout      = 1'b0;
    assign o_rsp_err      = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_next = S_ISSUE;
            S_ISSUE:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (w_timeout)         w_next = S_RESP;
                else if (!i_eng_ready) w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (w_done || w_timeout) w_next = S_RESP;
            S_RESP:      if (i_rsp_ready) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = 1'b0;
        o_eng_start = 1'b0;
        o_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE:  o_req_ready = i_eng_ready;
            S_ISSUE: o_eng_start = 1'b1;
            S_RESP:  o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operands only load on acceptance, so they stay frozen for the whole run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_eng_a <= '0;
            r_eng_b <= '0;
        end else if (w_accept) begin
            r_eng_a <= i_req_a;
            r_eng_b <= i_req_b;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_gcd     <= '0;
            r_rsp_coprime <= 1'b0;
        end else if (w_done) begin
            r_rsp_gcd     <= i_eng_r;
            r_rsp_coprime <= (i_eng_r == 7'd1);
        end else if (w_timeout) begin
            r_rsp_gcd     <= '0;
            r_rsp_coprime <= 1'b0;
        end
    end

    assign o_eng_a       = r_eng_a;
    assign o_eng_b       = r_eng_b;
    assign o_rsp_gcd     = r_rsp_gcd;
    assign o_rsp_coprime = r_rsp_coprime;

endmodule
